mlp_layer_scheduler: RTL
========================

# mlp_layer_scheduler

- Top-level sequencer for the two-layer MNIST MLP: 784 → 512 → 10.
- Starts the hidden fully-connected layer and waits for it to finish.
- Applies ReLU and requantization to the hidden layer's 32-bit outputs, producing the 8-bit activation vector that feeds the output layer.
- Starts the output layer, runs a sequential argmax over the logits and reports the predicted digit. It owns the inter-layer activation buffer and all layer start/done handshakes.

## Interface
- IN_SIZE, 784, input vector length (documentation only; the fc1 instance uses it)
- HID_SIZE, 512, hidden neurons (fc1 outputs, fc2 inputs)
- OUT_SIZE, 10, output classes
- WEIGHTS_WIDTH, 8, activation width (signed)
- BIAS_WIDTH, 32, accumulator/logit width (signed)
- SHIFT, 8, requantization right-shift
- WDOG_CYCLES, 4194304, watchdog limit per layer (used only with the watchdog macro)

Ports:
- clk  in  1  clock; all logic on the rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  begin inference; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of inference or watchdog abort
- error  out  1  watchdog abort flag; sticky until next accepted start
- pred_class  out  $clog2(OUT_SIZE)  argmax index
- pred_score  out  BIAS_WIDTH  winning logit
- fc1_start  out  1  one-cycle start pulse to the hidden layer
- fc1_done  in  1  hidden layer finished
- fc1_out  in  HID_SIZE x BIAS_WIDTH signed  hidden layer outputs
- fc2_start  out  1  one-cycle start pulse to the output layer
- fc2_done  in  1  output layer finished
- fc2_out  in  OUT_SIZE x BIAS_WIDTH signed  logits
- act_out  out  HID_SIZE x WEIGHTS_WIDTH signed  requantized activations; drives fc2 inputs

## Operation
- States:
  - IDLE → WAIT_L1 on start.
  - WAIT_L1 → REQUANT on fc1_done.
  - REQUANT → WAIT_L2 after index HID_SIZE-1.
  - WAIT_L2 → ARGMAX on fc2_done.
  - ARGMAX → DONE after index OUT_SIZE-1.
  - DONE → IDLE unconditionally.
- Leaving IDLE: registers fc1_start=1, clears error, and resets the index counter.
- REQUANT: one element per cycle, i = 0..HID_SIZE-1, with v = fc1_out[i].
  - v < 0 → act_out[i] = 0 (ReLU).
  - Otherwise s = v >> SHIFT; act_out[i] = min(s, 2^(WEIGHTS_WIDTH-1)-1).
  - Saturation is to +127 at default widths.
- REQUANT exit: registers fc2_start=1 together with the last write.
- ARGMAX: cycle 0 loads best = fc2_out[0], idx = 0. Each later cycle replaces the best only when fc2_out[j] > best (strictly greater), so ties resolve to the lowest index.
- DONE state: done=1; pred_class and pred_score are updated the same cycle and held until the next accepted start.
- act_out holds its values until overwritten in the next REQUANT.
- start while busy is ignored. fc1_done/fc2_done outside the matching WAIT state are ignored (covers stale pulses after a mid-run reset).
- Layer done inputs are level-tolerant: each is sampled only in its WAIT state.

## Timing
- Reset (rst_n low at an edge):
  - state = IDLE.
  - busy, done, error, fc1_start, fc2_start, pred_class, pred_score = 0.
  - All act_out = 0.
  - Counters = 0.
  - Reset wins over start. Reset mid-operation aborts within one cycle and issues no further start pulses.
- Edge sequence:
  - start sampled at edge k → fc1_start high during cycle k+1 only; busy high from cycle k+1.
  - fc1_done sampled at edge m → REQUANT writes act_out[0..HID_SIZE-1] at edges m+1..m+HID_SIZE → fc2_start high for one cycle after edge m+HID_SIZE.
  - fc2_done sampled at edge n → compares at edges n+1..n+OUT_SIZE → done high for one cycle after edge n+OUT_SIZE+1 → busy low the following cycle.
- Scheduler overhead excluding layer time: HID_SIZE + OUT_SIZE + 4 cycles.

## Configuration
- MLP_SCHED_WATCHDOG_EN defined:
  - A 23-bit cycle counter clears on entry to WAIT_L1/WAIT_L2.
  - If it reaches WDOG_CYCLES before the done input arrives: error=1, done pulse, pred_class=0, pred_score=0, return to IDLE.
- Undefined: the counter is not built, the WAIT states wait indefinitely, and error is tied 0.

## Structure
- mlp_pkg holds:
  - the state_t enum;
  - default size constants (784/512/10);
  - WEIGHTS_WIDTH/BIAS_WIDTH defaults;
  - a relu_requant function (value, shift → saturated signed byte).
- One natural sub-module: mlp_argmax, a sequential running-max with clear/valid-in/index interface, instantiated for the ARGMAX phase.

## Test plan
- Reset: hold rst_n=0 for 3 cycles mid-REQUANT → all outputs 0 and state IDLE; a later stray fc2_done=1 causes no state change.
- Requantization, SHIFT=8, fc1_out[0..4] = -5, 1000, 40000, 255, 256 → act_out = 0, 3, 127, 0, 1.
- Argmax:
  - fc2_out = {3,9,-2,9,0,...} → pred_class=1, pred_score=9.
  - All ten logits equal -1 → pred_class=0, pred_score=-1.
- Handshake, with layer models asserting done 20 cycles after their start:
  - fc1_start and fc2_start are each exactly one cycle wide.
  - A start pulse during WAIT_L1 is ignored.
  - done arrives 1+20+HID_SIZE+1+20+OUT_SIZE+2 cycles after start.
- Back-to-back inferences with different fc2_out (winner index 7, then 2) → pred_class 7, then 2; error stays 0.
- Watchdog, built with MLP_SCHED_WATCHDOG_EN and WDOG_CYCLES=100, fc2_done never asserted → error=1, a done pulse, then IDLE; the next start clears error.

Source files
------------

// File: rtl/mlp_pkg.sv
// Shared types, default sizes and the ReLU/requantization helper for the
// two-layer MNIST MLP scheduler (784 -> 512 -> 10).
package mlp_pkg;

    localparam int DEF_IN_SIZE       = 784;
    localparam int DEF_HID_SIZE      = 512;
    localparam int DEF_OUT_SIZE      = 10;
    localparam int DEF_WEIGHTS_WIDTH = 8;
    localparam int DEF_BIAS_WIDTH    = 32;
    localparam int DEF_SHIFT         = 8;
    localparam int DEF_WDOG_CYCLES   = 4194304;
    localparam int WDOG_W            = 23;

    // Largest positive activation, kept at accumulator width for comparisons.
    localparam logic signed [DEF_BIAS_WIDTH-1:0] ACT_MAX =
        DEF_BIAS_WIDTH'((2 ** (DEF_WEIGHTS_WIDTH - 1)) - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT_L1 = 3'd1,
        ST_REQUANT = 3'd2,
        ST_WAIT_L2 = 3'd3,
        ST_ARGMAX  = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // ReLU, arithmetic right shift, then saturate to the positive byte range.
    function automatic logic signed [DEF_WEIGHTS_WIDTH-1:0] relu_requant(
        input logic signed [DEF_BIAS_WIDTH-1:0] value,
        input int                               shift
    );
        logic signed [DEF_BIAS_WIDTH-1:0] scaled;
        scaled = value >>> shift;
        if (value[DEF_BIAS_WIDTH-1]) begin
            relu_requant = '0;
        end else if (scaled > ACT_MAX) begin
            relu_requant = ACT_MAX[DEF_WEIGHTS_WIDTH-1:0];
        end else begin
            relu_requant = scaled[DEF_WEIGHTS_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/mlp_argmax.sv
// Sequential running maximum: one candidate per valid cycle, index 0 always
// loads, later candidates replace the best only when strictly greater so
// ties keep the lowest index.
module mlp_argmax
    import mlp_pkg::*;
#(
    parameter int N = DEF_OUT_SIZE,
    parameter int W = DEF_BIAS_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 valid_in,
    input  logic [$clog2(N)-1:0] idx_in,
    input  logic signed [W-1:0]  data_in,
    output logic [$clog2(N)-1:0] best_idx,
    output logic signed [W-1:0]  best_val
);

    logic [$clog2(N)-1:0] best_idx_q, best_idx_d;
    logic signed [W-1:0]  best_val_q, best_val_d;

    // Next best candidate: clear, first load, strict improvement, or hold.
    always_comb begin
        best_idx_d = best_idx_q;
        best_val_d = best_val_q;
        if (clear) begin
            best_idx_d = '0;
            best_val_d = '0;
        end else if (valid_in && ((idx_in == '0) || (data_in > best_val_q))) begin
            best_idx_d = idx_in;
            best_val_d = data_in;
        end else begin
            best_idx_d = best_idx_q;
            best_val_d = best_val_q;
        end
    end

    // Best-so-far registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            best_idx_q <= '0;
            best_val_q <= '0;
        end else begin
            best_idx_q <= best_idx_d;
            best_val_q <= best_val_d;
        end
    end

    assign best_idx = best_idx_q;
    assign best_val = best_val_q;

endmodule

// File: rtl/mlp_layer_scheduler.sv
// Top-level sequencer: start fc1, requantize its outputs into the activation
// buffer, start fc2, argmax the logits and report the predicted digit.
// Optional per-layer watchdog: define MLP_SCHED_WATCHDOG_EN.
module mlp_layer_scheduler
    import mlp_pkg::*;
#(
    parameter int IN_SIZE       = DEF_IN_SIZE,
    parameter int HID_SIZE      = DEF_HID_SIZE,
    parameter int OUT_SIZE      = DEF_OUT_SIZE,
    parameter int WEIGHTS_WIDTH = DEF_WEIGHTS_WIDTH,
    parameter int BIAS_WIDTH    = DEF_BIAS_WIDTH,
    parameter int SHIFT         = DEF_SHIFT,
    parameter int WDOG_CYCLES   = DEF_WDOG_CYCLES
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            error,
    output logic [$clog2(OUT_SIZE)-1:0]     pred_class,
    output logic signed [BIAS_WIDTH-1:0]    pred_score,
    output logic                            fc1_start,
    input  logic                            fc1_done,
    input  logic signed [BIAS_WIDTH-1:0]    fc1_out [HID_SIZE],
    output logic                            fc2_start,
    input  logic                            fc2_done,
    input  logic signed [BIAS_WIDTH-1:0]    fc2_out [OUT_SIZE],
    output logic signed [WEIGHTS_WIDTH-1:0] act_out [HID_SIZE]
);

    localparam int CNT_W = $clog2(HID_SIZE);
    localparam int CLS_W = $clog2(OUT_SIZE);

    // Reject configurations the fixed-width watchdog counter cannot honour.
    if ((IN_SIZE < 1) || (WDOG_CYCLES < 1) || (WDOG_CYCLES > (2 ** WDOG_W))) begin : g_bad_cfg
        $error("mlp_layer_scheduler: unsupported IN_SIZE/WDOG_CYCLES");
    end

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                idx_q, idx_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;
    logic                            error_q, error_d;
    logic                            fc1_start_q, fc1_start_d;
    logic                            fc2_start_q, fc2_start_d;
    logic [CLS_W-1:0]                pred_class_q, pred_class_d;
    logic signed [BIAS_WIDTH-1:0]    pred_score_q, pred_score_d;
    logic signed [WEIGHTS_WIDTH-1:0] act_q [HID_SIZE];
    logic signed [WEIGHTS_WIDTH-1:0] act_d [HID_SIZE];

    logic                            am_clear_s;
    logic                            am_valid_s;
    logic signed [BIAS_WIDTH-1:0]    am_data_s;
    logic [CLS_W-1:0]                am_idx_s;
    logic signed [BIAS_WIDTH-1:0]    am_val_s;
    logic                            wdog_expired_s;

`ifdef MLP_SCHED_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Count cycles spent in a WAIT state; held at zero elsewhere so each wait starts fresh.
    always_comb begin
        if ((state_q == ST_WAIT_L1) || (state_q == ST_WAIT_L2)) begin
            wdog_d = wdog_q + WDOG_W'(1);
        end else begin
            wdog_d = '0;
        end
    end

    // Watchdog counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end

    assign wdog_expired_s = ((state_q == ST_WAIT_L1) || (state_q == ST_WAIT_L2))
                            && (wdog_q == WDOG_LAST);
`else
    assign wdog_expired_s = 1'b0;
`endif

    assign am_data_s = fc2_out[idx_q[CLS_W-1:0]];

    mlp_argmax #(
        .N (OUT_SIZE),
        .W (BIAS_WIDTH)
    ) u_argmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (am_clear_s),
        .valid_in (am_valid_s),
        .idx_in   (idx_q[CLS_W-1:0]),
        .data_in  (am_data_s),
        .best_idx (am_idx_s),
        .best_val (am_val_s)
    );

    // Sequencer next-state and registered-output values.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        act_d        = act_q;
        fc1_start_d  = 1'b0;
        fc2_start_d  = 1'b0;
        done_d       = 1'b0;
        error_d      = error_q;
        pred_class_d = pred_class_q;
        pred_score_d = pred_score_q;
        am_clear_s   = 1'b0;
        am_valid_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_WAIT_L1;
                    fc1_start_d = 1'b1;
                    error_d     = 1'b0;
                    idx_d       = '0;
                    am_clear_s  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_L1: begin
                if (fc1_done) begin
                    state_d = ST_REQUANT;
                    idx_d   = '0;
                end else if (wdog_expired_s) begin
                    state_d      = ST_IDLE;
                    error_d      = 1'b1;
                    done_d       = 1'b1;
                    pred_class_d = '0;
                    pred_score_d = '0;
                end else begin
                    state_d = ST_WAIT_L1;
                end
            end
            ST_REQUANT: begin
                act_d[idx_q] = relu_requant(fc1_out[idx_q], SHIFT);
                if (idx_q == CNT_W'(HID_SIZE - 1)) begin
                    state_d     = ST_WAIT_L2;
                    idx_d       = '0;
                    fc2_start_d = 1'b1;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_WAIT_L2: begin
                if (fc2_done) begin
                    state_d = ST_ARGMAX;
                    idx_d   = '0;
                end else if (wdog_expired_s) begin
                    state_d      = ST_IDLE;
                    error_d      = 1'b1;
                    done_d       = 1'b1;
                    pred_class_d = '0;
                    pred_score_d = '0;
                end else begin
                    state_d = ST_WAIT_L2;
                end
            end
            ST_ARGMAX: begin
                am_valid_s = 1'b1;
                if (idx_q == CNT_W'(OUT_SIZE - 1)) begin
                    state_d = ST_DONE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d      = ST_IDLE;
                done_d       = 1'b1;
                pred_class_d = am_idx_s;
                pred_score_d = am_val_s;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State, counter, status, result and activation-buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            fc1_start_q  <= 1'b0;
            fc2_start_q  <= 1'b0;
            pred_class_q <= '0;
            pred_score_q <= '0;
            for (int i = 0; i < HID_SIZE; i++) begin
                act_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            fc1_start_q  <= fc1_start_d;
            fc2_start_q  <= fc2_start_d;
            pred_class_q <= pred_class_d;
            pred_score_q <= pred_score_d;
            act_q        <= act_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign fc1_start  = fc1_start_q;
    assign fc2_start  = fc2_start_q;
    assign pred_class = pred_class_q;
    assign pred_score = pred_score_q;
    assign act_out    = act_q;

endmodule
